// File: rtl/spi_slave_fe.sv
// SPI slave front-end for the single-port RAM wrapper.
// Deserialises MOSI frames into rx_data/rx_valid words and serialises the
// RAM read response (tx_data/tx_valid) back out on MISO, MSB first.
// A frame is one SS_n-low period: one decision bit, then a 10-bit word.
// The decision bit picks the path. rd_addr_seen remembers whether a read
// address has already gone to the RAM, so the next read frame fetches data.

module spi_slave_fe #(
  parameter int MEM_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   SS_n,
  input  logic                   MOSI,
  output logic                   MISO,
  output logic [MEM_WIDTH+1:0]   rx_data,
  output logic                   rx_valid,
  input  logic [MEM_WIDTH-1:0]   tx_data,
  input  logic                   tx_valid
);

  localparam int RXW  = MEM_WIDTH + 2;
  localparam int CW   = $clog2(RXW + 1);
  localparam int TXCW = $clog2(MEM_WIDTH + 1);

  localparam logic [CW-1:0]   LAST_BIT   = CW'(RXW - 1);
  localparam logic [TXCW-1:0] TX_REMAIN  = TXCW'(MEM_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t                state;
  logic [CW-1:0]         bit_cnt;      // payload bits taken so far
  logic [RXW-1:0]        shift_reg;    // MOSI deserialiser
  logic                  word_done;    // 10 bits taken; ignore the rest of the frame
  logic                  rd_addr_seen; // a read address has been forwarded
  logic                  wait_tx;      // read-data word sent, waiting for RAM response
  logic [MEM_WIDTH-1:0]  tx_shift;     // remaining read-data bits, next one at MSB
  logic [TXCW-1:0]       tx_cnt;       // bits still to shift out after the current one

  // Protocol FSM, deserialiser, read-address tracking and MISO serialiser.
  // All outputs are registered; SS_n high aborts any frame from any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      word_done    <= 1'b0;
      rd_addr_seen <= 1'b0;
      wait_tx      <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
      MISO         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        // Partial frames are dropped; rd_addr_seen deliberately survives.
        state     <= IDLE;
        bit_cnt   <= '0;
        word_done <= 1'b0;
        wait_tx   <= 1'b0;
        tx_cnt    <= '0;
        tx_shift  <= '0;
        MISO      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state     <= CHK_CMD;
            bit_cnt   <= '0;
            word_done <= 1'b0;
            MISO      <= 1'b0;
          end

          CHK_CMD: begin
            // Decision bit only steers the FSM; it is not part of rx_data.
            MISO <= 1'b0;
            if (!MOSI)
              state <= WRITE;
            else if (rd_addr_seen)
              state <= READ_DATA;
            else
              state <= READ_ADD;
          end

          WRITE, READ_ADD, READ_DATA: begin
            if (!word_done) begin
              shift_reg <= {shift_reg[RXW-2:0], MOSI};
              if (bit_cnt == LAST_BIT) begin
                rx_data   <= {shift_reg[RXW-2:0], MOSI};
                rx_valid  <= 1'b1;
                word_done <= 1'b1;
                bit_cnt   <= '0;
                if (state == READ_ADD)
                  rd_addr_seen <= 1'b1;
                if (state == READ_DATA) begin
                  rd_addr_seen <= 1'b0;
                  wait_tx      <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end

            // tx_valid only counts while waiting and not already shifting.
            if (tx_cnt != '0) begin
              MISO     <= tx_shift[MEM_WIDTH-1];
              tx_shift <= tx_shift << 1;
              tx_cnt   <= tx_cnt - 1'b1;
            end else if (wait_tx && tx_valid) begin
              MISO     <= tx_data[MEM_WIDTH-1];
              tx_shift <= tx_data << 1;
              tx_cnt   <= TX_REMAIN;
              wait_tx  <= 1'b0;
            end else begin
              MISO <= 1'b0;
            end
          end

          default: begin
            state <= IDLE;
            MISO  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_fe.sv
// Self-checking bench for spi_slave_fe: table of frames plus hand-written
// abort/reset sequences, with an rx_data scoreboard queue.

module tb_spi_slave_fe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int tests = 0;
  int fails = 0;

  logic [9:0] exp_q[$];

  spi_slave_fe #(.MEM_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every rx_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && rx_valid) begin
      if (exp_q.size() == 0) begin
        chk("rx_unexpected", 32'(rx_valid), 32'd0);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e));
      end
    end
  end

  // One frame. Inputs are driven on negedges, outputs sampled there first.
  // abort_at >= 0 : raise SS_n after that many payload bits.
  // ser_abort >= 0: raise SS_n once MISO has shown that many read-data bits + 1.
  task automatic run_frame(input logic dec, input logic [9:0] word, input int nextra,
                           input int abort_at, input logic send_tx, input logic [7:0] txd,
                           input logic exp_ser, input int ser_abort);
    int  len;
    logic exp_bit;
    len = (abort_at >= 0) ? abort_at : 10 + nextra;
    $display("[TB] frame dec=%0b word=%03h extra=%0d abort=%0d tx=%0b txd=%02h ser=%0b",
             dec, word, nextra, abort_at, send_tx, txd, exp_ser);
    @(negedge clk);
    chk("miso_pre", 32'(MISO), 32'd0);
    SS_n = 1'b0;
    MOSI = 1'($urandom);
    @(negedge clk);
    chk("rx_valid_idle", 32'(rx_valid), 32'd0);
    MOSI = dec;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      chk("miso_payload", 32'(MISO), 32'd0);
      chk("rx_valid_timing", 32'(rx_valid), 32'((k == 10) && (abort_at < 0)));
      if (k < 10) MOSI = word[9-k];
      else        MOSI = 1'($urandom);
      if (k == 9 && abort_at < 0) exp_q.push_back(word);
    end
    if (abort_at < 0 && nextra == 0) begin
      @(negedge clk);
      chk("rx_valid_latency", 32'(rx_valid), 32'd1);
      MOSI = 1'($urandom);
      if (send_tx) begin
        tx_valid = 1'b1;
        tx_data  = txd;
      end
      for (int j = 0; j < 9; j++) begin
        @(negedge clk);
        if (j == 0) tx_data = ~txd;  // still valid, must be ignored now
        if (j == 1) tx_valid = 1'b0;
        exp_bit = (exp_ser && j < 8) ? txd[7-j] : 1'b0;
        chk("miso_serial", 32'(MISO), 32'(exp_bit));
        if (j == ser_abort) begin
          SS_n = 1'b1;
          break;
        end
      end
      tx_valid = 1'b0;
    end
    @(negedge clk);
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
    chk("miso_after", 32'(MISO), 32'd0);
    chk("rx_valid_after", 32'(rx_valid), 32'd0);
  endtask

  typedef struct {
    logic       dec;
    logic [9:0] word;
    int         nextra;
    logic       send_tx;
    logic [7:0] txd;
    logic [9:0] exp_rx;
    logic       exp_ser;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // dec, word, extra, send_tx, txd, expected rx_data, expected MISO serialisation
    vecs[0] = '{1'b0, 10'h0A5, 0, 1'b1, 8'h5A, 10'h0A5, 1'b0}; // write, tx ignored
    vecs[1] = '{1'b1, 10'h230, 0, 1'b1, 8'h77, 10'h230, 1'b0}; // READ_ADD, seen->1
    vecs[2] = '{1'b1, 10'h300, 0, 1'b1, 8'hC3, 10'h300, 1'b1}; // READ_DATA, seen->0
    vecs[3] = '{1'b1, 10'h3A7, 0, 1'b1, 8'h81, 10'h3A7, 1'b0}; // READ_ADD again
    vecs[4] = '{1'b0, 10'h155, 0, 1'b1, 8'h99, 10'h155, 1'b0}; // write keeps seen=1
    vecs[5] = '{1'b1, 10'h0F0, 0, 1'b1, 8'h5A, 10'h0F0, 1'b1}; // READ_DATA, raw cmd bits
    vecs[6] = '{1'b1, 10'h1E1, 0, 1'b1, 8'h24, 10'h1E1, 1'b0}; // READ_ADD
    vecs[7] = '{1'b1, 10'h3FF, 0, 1'b1, 8'h81, 10'h3FF, 1'b1}; // READ_DATA
    vecs[8] = '{1'b0, 10'h2C9, 4, 1'b0, 8'h00, 10'h2C9, 1'b0}; // 14 bits, first 10 kept
    vecs[9] = '{1'b0, 10'h000, 0, 1'b1, 8'hA5, 10'h000, 1'b0}; // all-zero write

    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_miso", 32'(MISO), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_frame(vecs[i].dec, vecs[i].word, vecs[i].nextra, -1, vecs[i].send_tx,
                vecs[i].txd, vecs[i].exp_ser, -1);
      chk("rx_data_hold", 32'(rx_data), 32'(vecs[i].exp_rx));
    end

    // SS_n abort after 6 write payload bits, then a normal frame right after.
    run_frame(1'b0, 10'h2DB, 0, 6, 1'b0, 8'h00, 1'b0, -1);
    chk("rx_data_kept_after_abort", 32'(rx_data), 32'h000);
    run_frame(1'b0, 10'h1C7, 0, -1, 1'b0, 8'h00, 1'b0, -1);

    // Abort during MISO serialisation once bit 3 is on the line.
    run_frame(1'b1, 10'h230, 0, -1, 1'b1, 8'h11, 1'b0, -1); // READ_ADD
    run_frame(1'b1, 10'h300, 0, -1, 1'b1, 8'h3C, 1'b1, 4);  // READ_DATA, abort
    repeat (3) begin
      @(negedge clk);
      chk("miso_idle_after_ser_abort", 32'(MISO), 32'd0);
    end
    run_frame(1'b1, 10'h211, 0, -1, 1'b1, 8'h5A, 1'b0, -1); // seen was cleared

    // Reset asserted while payload bit 5 of a write would be driven.
    $display("[TB] reset mid-write");
    @(negedge clk); SS_n = 1'b0;
    @(negedge clk); MOSI = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); MOSI = k[0];
    end
    @(negedge clk);
    rst_n = 1'b0;
    SS_n  = 1'b1;
    #1;
    chk("midreset_miso", 32'(MISO), 32'd0);
    chk("midreset_rx_valid", 32'(rx_valid), 32'd0);
    chk("midreset_rx_data", 32'(rx_data), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (14) begin
      @(negedge clk);
      chk("no_rx_after_reset", 32'(rx_valid), 32'd0);
    end
    run_frame(1'b0, 10'h0A5, 0, -1, 1'b1, 8'hFF, 1'b0, -1);
    run_frame(1'b1, 10'h245, 0, -1, 1'b1, 8'hE7, 1'b0, -1); // reset cleared seen
    run_frame(1'b1, 10'h300, 0, -1, 1'b1, 8'h96, 1'b1, -1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave_fe.md
Name: spi_slave_fe

Overview:
- SPI slave front-end that sits directly upstream of the single-port RAM: deserialises MOSI frames into `rx_data`/`rx_valid` words for the RAM.
- Serialises the RAM's `tx_data`/`tx_valid` read response back out on MISO.
- Owns the protocol state machine (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA) and the "read address received" tracking.
- Together with the RAM it forms the SPI wrapper.

Parameters:
- MEM_WIDTH, 8, RAM data width; `rx_data` is MEM_WIDTH+2 bits (2 command bits + payload).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SS_n  input  1  slave select, active low; a frame is one SS_n low period.
- MOSI  input  1  serial data in, MSB first, sampled on clk rising edge.
- MISO  output  1  serial read data out, MSB first.
- rx_data  output  MEM_WIDTH+2  received word to RAM: [9:8] command, [7:0] address/data.
- rx_valid  output  1  one-cycle strobe, rx_data valid.
- tx_data  input  MEM_WIDTH  read data from RAM.
- tx_valid  input  1  tx_data valid strobe from RAM.

Behaviour:
- Reset:
  - Applies immediately on rst_n low, including mid-frame.
  - state=IDLE, MISO=0, rx_data=0, rx_valid=0, bit counter=0, rd_addr_seen=0, tx shift register=0.
- SS_n high in any state: next state IDLE, MISO=0, counters cleared. A partial frame is discarded with no rx_valid. rd_addr_seen keeps its value.
- IDLE: SS_n sampled low -> CHK_CMD.
- CHK_CMD: MOSI is a decision bit only and is not stored.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_seen=0 -> READ_ADD.
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE, READ_ADD, READ_DATA: shift MOSI into a 10-bit register, MSB first, for exactly 10 cycles.
  - The cycle after the 10th bit: rx_data = shifted word (unmodified, command bits included), rx_valid=1 for exactly one cycle.
  - rx_data holds its value until the next completed word.
  - Bits beyond the 10th are ignored until SS_n returns high.
- READ_ADD completion: rd_addr_seen set to 1 in the same cycle rx_valid asserts.
- READ_DATA completion: rd_addr_seen cleared in the same cycle rx_valid asserts. The FSM then waits for tx_valid.
- tx_valid sampled high while waiting:
  - tx_data is latched.
  - Over the next 8 cycles MISO = tx_data[7], [6], ..., [0]; bit 7 appears the cycle after tx_valid is sampled.
  - MISO returns to 0 after bit 0.
  - tx_valid is ignored outside the waiting window and during serialisation.
- MISO is 0 whenever not serialising.
- The decision bit alone selects the state. The command bits in rx_data are forwarded as-is for the RAM to decode; the slave does no error flagging.
- Latencies, with cycle 0 = first IDLE cycle with SS_n low:
  - CHK_CMD at cycle 1.
  - Payload bits at cycles 2–11.
  - rx_valid at cycle 12.
- Back-to-back frames: SS_n must be high for ≥1 cycle between frames; the minimum frame is 12 SS_n-low cycles (write/address), or 12 + RAM latency + 8 (read data).

Test Plan:
- Reset mid-WRITE: rst_n low at payload bit 5 -> MISO=0, rx_valid=0, state IDLE, no rx_valid after release; the next write frame completes normally.
- Write frame: SS_n low, decision 0, then 10 bits 00_1010_0101 -> one rx_valid pulse with rx_data=10'h0A5, 12 cycles after SS_n sampled low; MISO stays 0.
- Read address then read data:
  - Frame 1: decision 1 + 10_0011_0000 -> rx_data=10'h230, rd_addr_seen=1.
  - Frame 2: decision 1 + 11_0000_0000 -> state READ_DATA, rx_data=10'h300, rd_addr_seen=0.
  - RAM tx_valid with tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1 on the 8 following cycles, then 0.
- Read without prior address: rd_addr_seen=0, decision 1 -> READ_ADD (not READ_DATA); the frame 11_xxxx sets rd_addr_seen=1.
- SS_n abort: SS_n high after 6 payload bits of a write -> no rx_valid, IDLE next cycle.
- SS_n abort during MISO serialisation at bit 3 -> MISO=0 immediately after, IDLE.
- Extra bits: 14 bits after decision in a WRITE frame -> exactly one rx_valid carrying the first 10 bits.
